dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's Memory-stage load/store traffic.
- Accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Performs RISC-V byte/half/word access with byte lanes, sign/zero extension and alignment checking, then returns a response over a second valid/ready handshake.
- Its busy output is the stall source for the pipeline while an access is outstanding.

Parameters:
- ADDR_W, 10, word-index width; storage is 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, wait states between accept and response (0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 of the access.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester consumes the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned access or illegal funct3.
- busy  output  1  access outstanding (state != IDLE); drives pipeline stall.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, wait counter=0, all latched request fields=0.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Storage contents are not cleared.
- Reset mid-operation returns to IDLE immediately. A store not yet committed is dropped. A response in flight is discarded.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/funct3/addr/wdata. Go to WAIT with counter=WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES=0.
  - WAIT: req_ready=0, busy=1. Counter decrements each cycle. At counter==0 go to RESP on the next edge.
  - RESP: rsp_valid=1; rsp_rdata/rsp_err are stable while rsp_valid=1 and rsp_ready=0. On rsp_ready=1, go to IDLE. rsp_valid falls the cycle after the handshake, and a new request may be accepted that cycle.
- Latency: accept edge to rsp_valid high = WAIT_CYCLES+1 cycles. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles when rsp_ready is held at 1.
- Commit point: on the edge entering RESP, the store is written (if legal) and load data is captured into the response register.
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*2^ADDR_W bytes.
- Loads (lane selected by addr[1:0]):
  - 000 lb: sign-extended byte.
  - 001 lh: sign-extended half, lane addr[1].
  - 010 lw: full word.
  - 100 lbu: zero-extended byte.
  - 101 lhu: zero-extended half.
- Stores:
  - 000 sb: writes only byte lane addr[1:0] with wdata[7:0].
  - 001 sh: writes half lane addr[1] with wdata[15:0].
  - 010 sw: writes all 4 bytes.
- Errors set rsp_err=1 and rsp_rdata=0, and no storage write occurs. Error cases:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - load funct3 in {011,110,111};
  - store funct3 in {011,1xx}.
- Within an error-free store, unselected byte lanes are unchanged.
- req_valid while busy is ignored (req_ready=0); no queuing.
- Changes to request inputs after the accept edge have no effect.

Test Plan:
- Reset, then sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> first rsp_valid exactly 3 cycles after accept (WAIT_CYCLES=2); lw returns rsp_rdata=0xDEADBEEF, rsp_err=0; busy high from the cycle after accept until the handshake completes.
- sb 0x12 data 0x000000AA over word 0x11223344, then lb 0x12 and lbu 0x12 -> word reads 0x11AA3344; lb returns 0xFFFFFFAA; lbu returns 0x000000AA.
- sh 0x16 data 0x8001, then lh 0x16 and lhu 0x16 -> lh returns 0xFFFF8001; lhu returns 0x00008001; lower half of the word unchanged.
- lw 0x21, sh 0x23, and load funct3=011 -> each gives rsp_err=1, rsp_rdata=0; a follow-up lw 0x20 shows the word unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP, pulsing req_valid meanwhile -> rsp_valid/rsp_rdata stable; req_ready=0; no second accept.
- Assert rst low during WAIT of a sw 0x30 data 0x12345678 -> outputs go to reset values immediately; a later lw 0x30 returns the prior contents, not 0x12345678.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder over valid/ready.
// The response appears WAIT_CYCLES+1 cycles after accept and is held until rsp_ready; no request is accepted while busy.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic               accept, commit;

    logic               lat_we;
    logic [2:0]         lat_f3;
    logic [ADDR_W+1:0]  lat_addr;
    logic [31:0]        lat_wdata;

    logic [31:0]        mem [2**ADDR_W];

    logic               addr_unused;
    assign addr_unused = ^req_addr[31:ADDR_W+2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = (state != S_IDLE);
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_we    <= 1'b0;
            lat_f3    <= 3'd0;
            lat_addr  <= '0;
            lat_wdata <= 32'd0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_f3    <= req_funct3;
            lat_addr  <= req_addr[ADDR_W+1:0];
            lat_wdata <= req_wdata;
        end
    end

    // With zero wait states the commit happens on the accept edge, so the live request is used.
    logic               acc_we;
    logic [2:0]         acc_f3;
    logic [ADDR_W+1:0]  acc_addr;
    logic [31:0]        acc_wdata;
    assign acc_we    = (state == S_IDLE) ? req_we                : lat_we;
    assign acc_f3    = (state == S_IDLE) ? req_funct3            : lat_f3;
    assign acc_addr  = (state == S_IDLE) ? req_addr[ADDR_W+1:0]  : lat_addr;
    assign acc_wdata = (state == S_IDLE) ? req_wdata             : lat_wdata;

    logic [1:0]         boff;
    logic [ADDR_W-1:0]  word_idx;
    logic               misalign, illegal, acc_err;
    assign boff     = acc_addr[1:0];
    assign word_idx = acc_addr[ADDR_W+1:2];

    always_comb begin
        misalign = 1'b0;
        case (acc_f3[1:0])
            2'b01:   misalign = boff[0];
            2'b10:   misalign = (boff != 2'b00);
            default: misalign = 1'b0;
        endcase
        if (acc_we) illegal = acc_f3[2] || (acc_f3[1:0] == 2'b11);
        else        illegal = (acc_f3 == 3'b011) || (acc_f3 == 3'b110) || (acc_f3 == 3'b111);
        acc_err = misalign || illegal;
    end

    logic [31:0] rd_word, load_data, wr_word, st_data;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [3:0]  byte_en;
    assign rd_word = mem[word_idx];
    assign rd_byte = rd_word[{boff, 3'b000} +: 8];
    assign rd_half = boff[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (acc_f3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_byte};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = 32'd0;
        endcase
        byte_en = 4'b0000;
        st_data = acc_wdata;
        case (acc_f3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << boff;
                st_data = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                byte_en = boff[1] ? 4'b1100 : 4'b0011;
                st_data = {2{acc_wdata[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = byte_en[i] ? st_data[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

    // Storage is deliberately not reset; rst gates the write so a dropped store never lands.
    always_ff @(posedge clk) begin
        if (rst && commit && acc_we && !acc_err) begin
            mem[word_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_rdata <= (acc_we || acc_err) ? 32'd0 : load_data;
            rsp_err   <= acc_err;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-array reference memory.
module tb_dmem_responder;
    localparam int ADDR_W      = 10;
    localparam int WAIT_CYCLES = 2;
    localparam int NBYTES      = 4 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_edge = 0;
    bit         outstanding = 1'b0;
    bit         seen = 1'b0;
    bit         hold = 1'b0;
    exp_t       sb[$];
    logic [7:0] mref [NBYTES];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference: byte-addressed memory, access size from funct3, plain arithmetic extension.
    function automatic void ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] wd, output exp_t e);
        int          a, size;
        logic        legal;
        logic [31:0] v;
        a     = int'(addr % NBYTES);
        size  = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        e.rdata = 32'd0;
        e.err   = !legal || (a % size != 0);
        if (e.err) return;
        if (we) begin
            for (int i = 0; i < size; i++) mref[a + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(mref[a + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
            e.rdata = v;
        end
    endfunction

    // Monitor: protocol, latency and scoreboard comparison, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_rsp_err", 32'(rsp_err), 32'd0);
            outstanding = 1'b0;
            seen        = 1'b0;
            sb.delete();
        end else begin
            chk("busy", 32'(busy), 32'(outstanding));
            chk("req_ready", 32'(req_ready), 32'(!outstanding));
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response at t=%0t", $time);
                end else begin
                    chk("rsp_rdata", rsp_rdata, sb[0].rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
                end
                if (!seen) begin
                    // RESP is entered WAIT_CYCLES edges after accept, so the first edge seeing rsp_valid is WAIT_CYCLES+1 after it.
                    chk("latency", 32'(cyc + 1 - acc_edge), 32'(WAIT_CYCLES + 1));
                    seen = 1'b1;
                end
                if (rsp_ready) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                    outstanding = 1'b0;
                    seen        = 1'b0;
                end
            end
            if (req_valid && req_ready) begin
                outstanding = 1'b1;
                acc_edge    = cyc + 1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit commit);
        exp_t e;
        bit   ok;
        ok         = 1'b0;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rst && req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no req_ready expected accept for addr %h", addr);
            req_valid = 1'b0;
            return;
        end
        if (commit) begin
            ref_access(we, f3, addr, wd, e);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!outstanding && sb.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: got %0d pending expected 0", sb.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        for (int w = 0; w < 16; w++) issue(1'b1, 3'b010, 32'(w * 4), $urandom, 1'b1);
        wait_idle();

        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        wait_idle();

        issue(1'b1, 3'b010, 32'h10, 32'h11223344, 1'b1);
        issue(1'b1, 3'b000, 32'h12, 32'h000000AA, 1'b1);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        issue(1'b0, 3'b000, 32'h12, 32'h0, 1'b1);
        issue(1'b0, 3'b100, 32'h12, 32'h0, 1'b1);
        wait_idle();

        issue(1'b1, 3'b001, 32'h16, 32'h00008001, 1'b1);
        issue(1'b0, 3'b001, 32'h16, 32'h0, 1'b1);
        issue(1'b0, 3'b101, 32'h16, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'h14, 32'h0, 1'b1);
        wait_idle();

        issue(1'b0, 3'b010, 32'h21, 32'h0, 1'b1);
        issue(1'b1, 3'b001, 32'h23, 32'hFFFF, 1'b1);
        issue(1'b0, 3'b011, 32'h20, 32'h0, 1'b1);
        issue(1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 1'b1);
        issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1);
        wait_idle();

        // Response held off while a competing store is pulsed at the request port.
        hold = 1'b1;
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL hold_rsp_timeout: got rsp_valid=0 expected 1");
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            req_we     = 1'b1;
            req_funct3 = 3'b010;
            req_addr   = 32'h10;
            req_wdata  = $urandom;
            req_valid  = (k % 2 == 0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        hold      = 1'b0;
        wait_idle();

        // Reset lands while the store is still in its wait states.
        issue(1'b1, 3'b010, 32'h30, 32'h12345678, 1'b0);
        rst = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_req_ready", 32'(req_ready), 32'd1);
        chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        issue(1'b0, 3'b010, 32'h30, 32'h0, 1'b1);
        wait_idle();

        for (int n = 0; n < 300; n++) begin
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  ($urandom & ~32'(NBYTES - 1)) | 32'($urandom_range(0, 63)), $urandom, 1'b1);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
